mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator side of the data-memory port used by the multicycle datapath.
- Accepts one word-access request at a time from the control unit over a valid/ready handshake.
- Converts the 32-bit byte address to the memory's 6-bit word address and drives address, writeData, memwrite and memread with correct timing.
- Captures read data and returns one response per request, with an error flag for illegal addresses.

Parameters:
- ADDR_W, 6: memory word-address width; the valid byte-address range is 0 to 4*2^ADDR_W-1.
- DATA_W, 32: data word width.
- READ_LAT, 1: cycles memread is held before out32 is sampled; legal values 1..4.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  mem_master can accept a request; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  request rejected: misaligned or out of range.
- err_count  out  8  saturating count of rejected requests.
- address  out  ADDR_W  to memory.
- writeData  out  DATA_W  to memory.
- memwrite  out  1  to memory; registered.
- memread  out  1  to memory; registered.
- out32  in  DATA_W  from memory.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - memread, memwrite, address, writeData, rsp_valid, rsp_rdata, rsp_err and err_count all = 0.
  - req_ready = 1 once the block is in IDLE.
- Reset asserted mid-transaction drops the strobes immediately. The transaction is discarded and no response is issued.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata.
  - Error check: error if req_addr[1:0]!=0 or req_addr[31:ADDR_W+2]!=0.
    - Error → RESP with rsp_err=1, rsp_rdata=0, err_count+1 (saturates at 255). No memory strobe is issued.
    - Else write → WRITE.
    - Else read → READ, with the latency counter loaded to READ_LAT-1.
  - address = req_addr[ADDR_W+1:2], registered at accept.
- WRITE:
  - memwrite=1 for exactly one cycle, with address and writeData stable; the memory commits on that cycle's closing edge.
  - Next state RESP, rsp_rdata=0.
- READ:
  - memread=1 for READ_LAT consecutive cycles with address stable.
  - On the last cycle (counter==0), out32 is registered into rsp_rdata.
  - Next state RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err hold steady until rsp_ready.
  - On rsp_valid & rsp_ready → IDLE and rsp_valid drops.
  - A new request can be accepted the following cycle; there is no accept in the same cycle as the response handshake.
- Invariants:
  - memread and memwrite are never both 1.
  - Both are 0 in IDLE and RESP.
  - address and writeData hold their last value outside active strobes.
- Latency, accept edge = cycle 0:
  - Write: memwrite high in cycle 1, rsp_valid in cycle 2.
  - Read: rsp_valid in cycle READ_LAT+1.
  - Error: rsp_valid in cycle 1.
- rsp_ready held high continuously gives back-to-back throughput of one transaction per (latency+1) cycles.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package mem_master_pkg:
  - State enum (IDLE, WRITE, READ, RESP).
  - Default ADDR_W, DATA_W and READ_LAT constants.
  - ERR_CNT_W = 8.
- One combinational sub-module, mem_addr_check: maps a byte address to the word address and flags misaligned or out-of-range addresses.

Test Plan:
1. Reset, then write addr=0x00 data=0x00000001, rsp_ready=1 → memwrite=1 for exactly 1 cycle with address=0 and writeData=1; rsp_valid in cycle 2 with rsp_err=0 and rsp_rdata=0.
2. Read addr=0x00 after test 1 → memread=1 for 1 cycle; rsp_rdata=0x00000001. Then write 0x0 to the same address and read back → 0x00000000.
3. Write 0xDEADBEEF to addr=0xFC (word 63), read back → 0xDEADBEEF. Then read addr=0x100 → rsp_err=1, no strobes, err_count=1.
4. Read addr=0x02 (misaligned) → rsp_err=1 at cycle 1 with no memread. Repeat 300 times → err_count saturates at 255.
5. rsp_ready held low for 5 cycles after a read → rsp_valid and rsp_rdata stable, req_ready=0, and a req_valid pulse is ignored (no strobe).
6. READ_LAT=3, with rst_n pulsed low during the 2nd memread cycle → memread drops immediately, no rsp_valid, state IDLE, and a subsequent read completes normally.

Source files
------------

// File: rtl/mem_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_master_pkg                                                     |
// | Shared types and default constants for the data-memory initiator.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package mem_master_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int READ_LAT_DEF = 1;
  localparam int ERR_CNT_W    = 8;
  // Latency counter only ever holds READ_LAT-1, and READ_LAT tops out at 4
  localparam int CNT_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_master_addr_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_addr_check                                                     |
// | Byte-to-word address mapping with misalignment/range detection.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mem_addr_check #(
  parameter int ADDR_W = 6
) (
  input  logic [31:0]       byte_addr,
  output logic [ADDR_W-1:0] word_addr,
  output logic              addr_err
);

  // Word index is the byte address with the two byte-lane bits removed;
  // any set lane bit or any bit above the memory's reach is illegal.
  always_comb begin
    word_addr = byte_addr[ADDR_W+1:2];
    addr_err  = (|byte_addr[1:0]) | (|byte_addr[31:ADDR_W+2]);
  end

endmodule
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_master                                                         |
// | Valid/ready request front end driving a word-addressed memory with |
// | registered strobes, one response per request, and error counting.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    address,
  output logic [DATA_W-1:0]    writeData,
  output logic                 memwrite,
  output logic                 memread,
  input  logic [DATA_W-1:0]    out32
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic                  memwrite_q, memwrite_d;
  logic                  memread_q, memread_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

  logic [ADDR_W-1:0]     w_word_addr;
  logic                  w_addr_err;

  mem_addr_check #(
    .ADDR_W (ADDR_W)
  ) u_addr_check (
    .byte_addr (req_addr),
    .word_addr (w_word_addr),
    .addr_err  (w_addr_err)
  );

  // Next-state and next-output logic; strobes are computed one cycle early
  // so they come straight out of flops alongside the state they belong to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    memwrite_d   = 1'b0;
    memread_d    = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    err_count_d  = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_addr_err) begin
            // Rejected: straight to response, memory untouched
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
          end else begin
            address_d    = w_word_addr;
            write_data_d = req_wdata;
            rsp_err_d    = 1'b0;
            rsp_rdata_d  = '0;
            if (req_we) begin
              state_d    = ST_WRITE;
              memwrite_d = 1'b1;
            end else begin
              state_d   = ST_READ;
              memread_d = 1'b1;
              cnt_d     = CNT_W'(READ_LAT - 1);
            end
          end
        end
      end
      ST_WRITE: begin
        // Memory commits on the closing edge of the single memwrite cycle
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      ST_READ: begin
        if (cnt_q == '0) begin
          rsp_rdata_d = out32;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          memread_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight access at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      memwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      memwrite_q   <= memwrite_d;
      memread_q    <= memread_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      err_count_q  <= err_count_d;
    end
  end

  // Port mapping of the registered state
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
    err_count = err_count_q;
    address   = address_q;
    writeData = write_data_q;
    memwrite  = memwrite_q;
    memread   = memread_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_master                                                      |
// | Directed bench: instance 0 uses READ_LAT=1, instance 1 READ_LAT=3. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst_n_a     [2];
  logic        req_valid_a [2];
  logic        req_ready_a [2];
  logic        req_we_a    [2];
  logic [31:0] req_addr_a  [2];
  logic [31:0] req_wdata_a [2];
  logic        rsp_valid_a [2];
  logic        rsp_ready_a [2];
  logic [31:0] rsp_rdata_a [2];
  logic        rsp_err_a   [2];
  logic [7:0]  err_count_a [2];
  logic [5:0]  address_a   [2];
  logic [31:0] writeData_a [2];
  logic        memwrite_a  [2];
  logic        memread_a   [2];
  logic [31:0] out32_a     [2];

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_master #(.ADDR_W(6), .DATA_W(32), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n_a[0]),
    .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_we(req_we_a[0]),
    .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]), .rsp_rdata(rsp_rdata_a[0]),
    .rsp_err(rsp_err_a[0]), .err_count(err_count_a[0]),
    .address(address_a[0]), .writeData(writeData_a[0]),
    .memwrite(memwrite_a[0]), .memread(memread_a[0]), .out32(out32_a[0])
  );

  mem_master #(.ADDR_W(6), .DATA_W(32), .READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n_a[1]),
    .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_we(req_we_a[1]),
    .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]), .rsp_rdata(rsp_rdata_a[1]),
    .rsp_err(rsp_err_a[1]), .err_count(err_count_a[1]),
    .address(address_a[1]), .writeData(writeData_a[1]),
    .memwrite(memwrite_a[1]), .memread(memread_a[1]), .out32(out32_a[1])
  );

  // Memory models: synchronous write, asynchronous read
  always @(posedge clk) if (memwrite_a[0]) mem0[address_a[0]] <= writeData_a[0];
  always @(posedge clk) if (memwrite_a[1]) mem1[address_a[1]] <= writeData_a[1];
  assign out32_a[0] = mem0[address_a[0]];
  assign out32_a[1] = mem1[address_a[1]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready high; checks strobes, latency and response
  task automatic txn(input int s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic exp_err,
                     input logic [31:0] exp_rdata, input int exp_lat,
                     input int exp_nw, input int exp_nr);
    int  c;
    int  nw;
    int  nr;
    bit  got;
    logic [31:0] exp_word;
    exp_word = {26'd0, addr[7:2]};
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready_a[s]}, 32'd1);
    req_valid_a[s] = 1'b1;
    req_we_a[s]    = we;
    req_addr_a[s]  = addr;
    req_wdata_a[s] = wdata;
    @(posedge clk);
    c = 0; nw = 0; nr = 0; got = 1'b0;
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      req_valid_a[s] = 1'b0;
      if (memwrite_a[s] && memread_a[s]) chk("strobe_mutex", 32'd1, 32'd0);
      if (memwrite_a[s]) begin
        nw++;
        chk("wr_address", {26'd0, address_a[s]}, exp_word);
        chk("wr_data", writeData_a[s], wdata);
      end
      if (memread_a[s]) begin
        nr++;
        chk("rd_address", {26'd0, address_a[s]}, exp_word);
      end
      if (rsp_valid_a[s]) got = 1'b1;
    end
    chk("rsp_seen", {31'd0, got}, 32'd1);
    chk("latency", c, exp_lat);
    chk("memwrite_cycles", nw, exp_nw);
    chk("memread_cycles", nr, exp_nr);
    chk("rsp_err", {31'd0, rsp_err_a[s]}, {31'd0, exp_err});
    chk("rsp_rdata", rsp_rdata_a[s], exp_rdata);
    @(negedge clk);
    chk("rsp_valid_drop", {31'd0, rsp_valid_a[s]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    for (int s = 0; s < 2; s++) begin
      rst_n_a[s] = 1'b0; req_valid_a[s] = 1'b0; req_we_a[s] = 1'b0;
      req_addr_a[s] = 32'h0; req_wdata_a[s] = 32'h0; rsp_ready_a[s] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n_a[0] = 1'b1;
    rst_n_a[1] = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_memread", {31'd0, memread_a[0]}, 32'd0);
    chk("rst_memwrite", {31'd0, memwrite_a[0]}, 32'd0);
    chk("rst_address", {26'd0, address_a[0]}, 32'd0);
    chk("rst_writeData", writeData_a[0], 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_a[0]}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_a[0], 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_a[0]}, 32'd0);
    chk("rst_err_count", {24'd0, err_count_a[0]}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready_a[0]}, 32'd1);

    // Basic write / read / overwrite
    txn(0, 1'b1, 32'h00, 32'h0000_0001, 1'b0, 32'h0, 2, 1, 0);
    txn(0, 1'b0, 32'h00, 32'h0,         1'b0, 32'h0000_0001, 2, 0, 1);
    txn(0, 1'b1, 32'h00, 32'h0,         1'b0, 32'h0, 2, 1, 0);
    txn(0, 1'b0, 32'h00, 32'h0,         1'b0, 32'h0, 2, 0, 1);

    // Top word and first out-of-range address
    txn(0, 1'b1, 32'hFC,  32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 0);
    txn(0, 1'b0, 32'hFC,  32'h0,         1'b0, 32'hDEAD_BEEF, 2, 0, 1);
    txn(0, 1'b0, 32'h100, 32'h0,         1'b1, 32'h0, 1, 0, 0);
    chk("err_count_1", {24'd0, err_count_a[0]}, 32'd1);

    // Misaligned accesses until the error counter saturates
    txn(0, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    chk("err_count_2", {24'd0, err_count_a[0]}, 32'd2);
    for (int k = 0; k < 299; k++) begin
      txn(0, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    end
    chk("err_count_sat", {24'd0, err_count_a[0]}, 32'd255);

    // Back-pressure on the response; a request pulse meanwhile is ignored
    rsp_ready_a[0] = 1'b0;
    @(negedge clk);
    req_valid_a[0] = 1'b1; req_we_a[0] = 1'b0; req_addr_a[0] = 32'hFC;
    @(posedge clk);
    begin
      int c;
      c = 0;
      @(negedge clk);
      req_valid_a[0] = 1'b0;
      while (!rsp_valid_a[0] && c < 10) begin
        @(negedge clk);
        c++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid_a[0]}, 32'd1);
      chk("bp_rsp_rdata", rsp_rdata_a[0], 32'hDEAD_BEEF);
      chk("bp_req_ready", {31'd0, req_ready_a[0]}, 32'd0);
      chk("bp_no_strobe", {30'd0, memread_a[0], memwrite_a[0]}, 32'd0);
      req_valid_a[0] = (i == 0);
      req_we_a[0]    = 1'b1;
      req_addr_a[0]  = 32'h00;
      req_wdata_a[0] = 32'h1234_5678;
      @(negedge clk);
    end
    req_valid_a[0] = 1'b0;
    rsp_ready_a[0] = 1'b1;
    @(negedge clk);
    chk("bp_rsp_valid_drop", {31'd0, rsp_valid_a[0]}, 32'd0);
    chk("bp_req_ready_back", {31'd0, req_ready_a[0]}, 32'd1);
    txn(0, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0, 2, 0, 1);

    // READ_LAT=3 instance: reset during the second memread cycle
    txn(1, 1'b1, 32'h04, 32'hA5A5_A5A5, 1'b0, 32'h0, 2, 1, 0);
    @(negedge clk);
    req_valid_a[1] = 1'b1; req_we_a[1] = 1'b0; req_addr_a[1] = 32'h04;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[1] = 1'b0;
    chk("l3_memread_c1", {31'd0, memread_a[1]}, 32'd1);
    @(negedge clk);
    chk("l3_memread_c2", {31'd0, memread_a[1]}, 32'd1);
    rst_n_a[1] = 1'b0;
    #1;
    chk("l3_rst_memread", {31'd0, memread_a[1]}, 32'd0);
    chk("l3_rst_rsp_valid", {31'd0, rsp_valid_a[1]}, 32'd0);
    chk("l3_rst_idle", {31'd0, req_ready_a[1]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("l3_rst_quiet", {30'd0, rsp_valid_a[1], memread_a[1]}, 32'd0);
    end
    rst_n_a[1] = 1'b1;
    @(negedge clk);
    chk("l3_no_rsp_after_rst", {31'd0, rsp_valid_a[1]}, 32'd0);
    txn(1, 1'b0, 32'h04, 32'h0, 1'b0, 32'hA5A5_A5A5, 4, 0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
